// File: rtl/imager_capture_sequencer.sv
// Frame-capture scheduler for NUM_CAMS Stonyman channels: round-robin or simultaneous triggering,
// frame-period pacing. Define IMAGER_SEQ_WATCHDOG_EN to add the per-capture timeout watchdog.
module imager_capture_sequencer #(
    parameter int NUM_CAMS  = 2,
    parameter int IDX_W     = 3,
    parameter int PERIOD_W  = 24,
    parameter int TIMEOUT_W = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [1:0]           mode,
    input  logic [NUM_CAMS-1:0]  cam_enable,
    input  logic [PERIOD_W-1:0]  frame_period,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    input  logic                 clear_status,
    input  logic [NUM_CAMS-1:0]  cam_busy,
    input  logic [NUM_CAMS-1:0]  cam_frame_done,
    output logic [NUM_CAMS-1:0]  cam_frame_start,
    output logic [NUM_CAMS-1:0]  cam_reset,
    output logic [IDX_W-1:0]     active_cam,
    output logic                 busy,
    output logic                 round_done,
    output logic                 timeout_flag,
    output logic [NUM_CAMS-1:0]  timeout_mask,
    output logic [15:0]          frame_count
);

    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = $clog2(NUM_CAMS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_WAIT_READY, S_TRIGGER, S_WAIT_DONE, S_PERIOD_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           mode_q;
    logic [NUM_CAMS-1:0]  en_q, done_mask_q;
    logic [PTR_W-1:0]     ptr_q;
    logic [IDX_W-1:0]     active_q;
    logic                 stop_req_q;
    logic [PERIOD_W-1:0]  period_q, period_inc;
    logic [15:0]          frame_count_q;
    logic                 round_done_q;

    logic                 sim, cont, expire, round_end, begin_round;
    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic [NUM_CAMS-1:0]  act_oh, new_done, mask_n, frame_start, cam_rst;
    logic [CNT_W-1:0]     fc_add;

    assign sim    = mode_q[1];
    assign cont   = mode_q[0];
    assign act_oh = NUM_CAMS'(1) << active_q;

    // Elapsed cycles since round start, counting the current cycle; saturates.
    assign period_inc = (&period_q) ? period_q : period_q + PERIOD_W'(1);

    assign new_done = (state_q != S_WAIT_DONE) ? '0 :
                      cam_frame_done & (sim ? (en_q & ~done_mask_q) : act_oh);
    assign mask_n   = done_mask_q | new_done;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = NUM_CAMS - 1; i >= 0; i--) begin
            if (en_q[i] && (PTR_W'(i) >= ptr_q)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        fc_add = '0;
        for (int i = 0; i < NUM_CAMS; i++) fc_add = fc_add + CNT_W'(new_done[i]);
    end

`ifdef IMAGER_SEQ_WATCHDOG_EN
    logic [TIMEOUT_W-1:0] wd_q;
    logic [TIMEOUT_W:0]   wd_inc;
    assign wd_inc = {1'b0, wd_q} + (TIMEOUT_W + 1)'(1);
    // Counts the current WAIT_DONE cycle, so expiry lands timeout_cycles after the trigger.
    assign expire = (timeout_cycles != '0) && (wd_inc >= {1'b0, timeout_cycles});
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        round_end   = 1'b0;
        frame_start = '0;
        cam_rst     = '0;
        unique case (state_q)
            S_IDLE:
                if (start && cam_enable != '0) state_d = S_SELECT;
            S_SELECT:
                if (sim || sel_found) state_d = S_WAIT_READY;
                else                  round_end = 1'b1;
            S_WAIT_READY:
                if ((cam_busy & (sim ? en_q : act_oh)) == '0) state_d = S_TRIGGER;
            S_TRIGGER: begin
                frame_start = sim ? en_q : act_oh;
                state_d     = S_WAIT_DONE;
            end
            S_WAIT_DONE:
                if (sim) begin
                    if (mask_n == en_q) begin
                        round_end = 1'b1;
                    end else if (expire) begin
                        cam_rst   = en_q & ~mask_n;
                        round_end = 1'b1;
                    end
                end else if (|new_done) begin
                    state_d = S_SELECT;
                end else if (expire) begin
                    cam_rst = act_oh;
                    state_d = S_SELECT;
                end
            S_PERIOD_WAIT:
                if (stop_req_q || stop)  state_d = S_IDLE;
                else if (period_inc >= frame_period)
                    state_d = (cam_enable != '0) ? S_SELECT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (round_end) state_d = (!cont || stop_req_q || stop) ? S_IDLE : S_PERIOD_WAIT;
    end

    assign begin_round = (state_q == S_IDLE || state_q == S_PERIOD_WAIT) && state_d == S_SELECT;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            mode_q        <= '0;
            en_q          <= '0;
            done_mask_q   <= '0;
            ptr_q         <= '0;
            active_q      <= '0;
            stop_req_q    <= 1'b0;
            period_q      <= '0;
            frame_count_q <= '0;
            round_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            round_done_q  <= round_end;
            frame_count_q <= frame_count_q + 16'(fc_add);
            if (begin_round) begin
                en_q     <= cam_enable;
                ptr_q    <= '0;
                period_q <= '0;
                if (state_q == S_IDLE) mode_q <= mode;
            end else if (state_q != S_IDLE) begin
                period_q <= period_inc;
            end
            if (state_q == S_SELECT && !sim && sel_found) active_q <= sel_idx;
            if (state_q == S_WAIT_DONE && state_d == S_SELECT)
                ptr_q <= PTR_W'(active_q) + PTR_W'(1);
            if (state_q == S_TRIGGER)        done_mask_q <= '0;
            else if (state_q == S_WAIT_DONE) done_mask_q <= mask_n;
            if (state_q != S_IDLE && state_d == S_IDLE) stop_req_q <= 1'b0;
            else if (state_q != S_IDLE && stop)         stop_req_q <= 1'b1;
        end
    end

`ifdef IMAGER_SEQ_WATCHDOG_EN
    logic                flag_q;
    logic [NUM_CAMS-1:0] tmask_q;

    // A new expiry in the same cycle as clear_status survives the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q    <= '0;
            flag_q  <= 1'b0;
            tmask_q <= '0;
        end else begin
            if (state_q == S_TRIGGER)                         wd_q <= '0;
            else if (state_q == S_WAIT_DONE && !wd_inc[TIMEOUT_W]) wd_q <= wd_inc[TIMEOUT_W-1:0];
            flag_q  <= (clear_status ? 1'b0 : flag_q) | (|cam_rst);
            tmask_q <= (clear_status ? '0 : tmask_q) | cam_rst;
        end
    end

    assign cam_reset    = reset ? '0 : cam_rst;
    assign timeout_flag = flag_q;
    assign timeout_mask = tmask_q;
`else
    logic unused_wd;
    assign unused_wd    = ^{timeout_cycles, clear_status, cam_rst};
    assign cam_reset    = '0;
    assign timeout_flag = 1'b0;
    assign timeout_mask = '0;
`endif

    assign cam_frame_start = reset ? '0 : frame_start;
    assign active_cam      = active_q;
    assign busy            = (state_q != S_IDLE);
    assign round_done      = round_done_q;
    assign frame_count     = frame_count_q;

endmodule

// File: tb/tb_imager_capture_sequencer.sv
// Scoreboard bench for imager_capture_sequencer: directed rounds push expected pulse events,
// a negedge monitor pops and checks them (value plus cycle spacing).
module tb_imager_capture_sequencer;

    localparam int NC = 2;

    logic          clk = 1'b0;
    logic          reset, start, stop, clear_status;
    logic [1:0]    mode;
    logic [NC-1:0] cam_enable, cam_busy, cam_frame_done;
    logic [23:0]   frame_period, timeout_cycles;
    logic [NC-1:0] cam_frame_start, cam_reset, timeout_mask;
    logic [2:0]    active_cam;
    logic          busy, round_done, timeout_flag;
    logic [15:0]   frame_count;

    imager_capture_sequencer #(.NUM_CAMS(NC), .IDX_W(3), .PERIOD_W(24), .TIMEOUT_W(24)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
        .cam_enable(cam_enable), .frame_period(frame_period), .timeout_cycles(timeout_cycles),
        .clear_status(clear_status), .cam_busy(cam_busy), .cam_frame_done(cam_frame_done),
        .cam_frame_start(cam_frame_start), .cam_reset(cam_reset), .active_cam(active_cam),
        .busy(busy), .round_done(round_done), .timeout_flag(timeout_flag),
        .timeout_mask(timeout_mask), .frame_count(frame_count)
    );

    initial forever #5 clk = ~clk;

    // kind: 0 = cam_frame_start, 1 = cam_reset, 2 = round_done
    typedef struct {
        int         kind;
        logic [1:0] val;
        int         ref_kind;
        int         gap;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0, bad = 0;
    int  cyc = 0;
    int  last_cyc[3];
    int  dly[NC];
    bit  never[NC];
    int  cnt[NC];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [1:0] v, input int rk, input int g);
        ev_t e;
        e.kind = k; e.val = v; e.ref_kind = rk; e.gap = g;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        chk("drain_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic mon_ev(input int k, input logic [1:0] v);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event kind=%0d act=%b exp=none", k, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v) begin
                bad++;
                $display("FAIL event act=kind%0d/%b exp=kind%0d/%b", k, v, e.kind, e.val);
            end
            if (e.gap >= 0) begin
                total++;
                if (cyc - last_cyc[e.ref_kind] != e.gap) begin
                    bad++;
                    $display("FAIL gap kind=%0d act=%0d exp=%0d", k, cyc - last_cyc[e.ref_kind], e.gap);
                end
            end
        end
        last_cyc[k] = cyc;
    endtask

    // Monitor
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (cam_frame_start != '0) mon_ev(0, cam_frame_start);
            if (cam_reset != '0)       mon_ev(1, cam_reset);
            if (round_done)            mon_ev(2, 2'b01);
        end
    end

    // Camera model: done pulse dly[i] cycles after the trigger cycle
    initial begin
        cam_frame_done = '0;
        for (int i = 0; i < NC; i++) cnt[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            cam_frame_done = '0;
            for (int i = 0; i < NC; i++) begin
                if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) cam_frame_done[i] = 1'b1;
                end
                if (cam_frame_start[i] && !never[i]) cnt[i] = dly[i];
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check_reset_state();
        chk("rst_busy", busy, 0);
        chk("rst_start", cam_frame_start, 0);
        chk("rst_camreset", cam_reset, 0);
        chk("rst_round_done", round_done, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_active", active_cam, 0);
        chk("rst_flag", timeout_flag, 0);
        chk("rst_mask", timeout_mask, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; clear_status = 1'b0; mode = 2'd0;
        cam_enable = '0; cam_busy = '0; frame_period = '0; timeout_cycles = '0;
        dly[0] = 50; dly[1] = 50; never[0] = 0; never[1] = 0;
        for (int i = 0; i < 3; i++) last_cyc[i] = 0;
        tick(3);
        check_reset_state();
        reset = 1'b0;
        tick(2);

        // single sequential round, both cameras
        mode = 2'd0; cam_enable = 2'b11;
        push(0, 2'b01, 0, -1); push(0, 2'b10, 0, 53); push(2, 2'b01, 0, 52);
        pulse_start();
        drain(500);
        chk("A_frame_count", frame_count, 2);
        chk("A_busy", busy, 0);

        // only cam1 enabled
        cam_enable = 2'b10;
        push(0, 2'b10, 0, -1); push(2, 2'b01, 0, 52);
        pulse_start();
        drain(500);
        chk("B_active", active_cam, 1);
        chk("B_frame_count", frame_count, 3);

        // start with no camera enabled is ignored
        cam_enable = 2'b00;
        pulse_start();
        tick(3);
        chk("Z_busy", busy, 0);
        chk("Z_frame_count", frame_count, 3);

        // continuous round-robin, period 1000, stop during third round
        mode = 2'd1; cam_enable = 2'b11; frame_period = 24'd1000;
        push(0, 2'b01, 0, -1); push(0, 2'b10, 0, 53); push(2, 2'b01, 0, 52);
        for (int r = 0; r < 2; r++) begin
            push(0, 2'b01, 0, -1); push(0, 2'b10, 0, 53); push(2, 2'b01, 2, 1000);
        end
        pulse_start();
        tick(2030);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("C_busy_after_stop", busy, 1);
        drain(3000);
        chk("C_idle", busy, 0);
        tick(1100);
        chk("C_still_idle", busy, 0);
        chk("C_frame_count", frame_count, 9);

        // simultaneous single, cam1 busy for 30 cycles
        mode = 2'd2; cam_enable = 2'b11; cam_busy = 2'b10;
        dly[0] = 20; dly[1] = 40;
        push(0, 2'b11, 0, -1); push(2, 2'b01, 0, 41);
        pulse_start();
        tick(29);
        chk("D_no_trigger_while_busy", exp_q.size(), 2);
        cam_busy = 2'b00;
        drain(500);
        chk("D_frame_count", frame_count, 11);
        chk("D_busy", busy, 0);

        mode = 2'd0; cam_enable = 2'b11; dly[0] = 50; timeout_cycles = 24'd200;
`ifdef IMAGER_SEQ_WATCHDOG_EN
        // cam1 never completes -> watchdog reset 200 cycles after its trigger
        never[1] = 1;
        push(0, 2'b01, 0, -1); push(0, 2'b10, 0, 53); push(1, 2'b10, 0, 200); push(2, 2'b01, 1, 2);
        pulse_start();
        drain(800);
        chk("E_flag", timeout_flag, 1);
        chk("E_mask", timeout_mask, 2'b10);
        chk("E_frame_count", frame_count, 12);
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        chk("E_flag_clr", timeout_flag, 0);
        chk("E_mask_clr", timeout_mask, 0);

        // done on the expiry cycle wins
        never[1] = 0; dly[1] = 200;
        push(0, 2'b01, 0, -1); push(0, 2'b10, 0, 53); push(2, 2'b01, 0, 202);
        pulse_start();
        drain(800);
        chk("E2_frame_count", frame_count, 14);
        chk("E2_flag", timeout_flag, 0);
        chk("E2_mask", timeout_mask, 0);

        // watchdog disabled: hung cam0 keeps sequencer busy
        timeout_cycles = '0; never[0] = 1; cam_enable = 2'b01;
        push(0, 2'b01, 0, -1);
        pulse_start();
        tick(20);
        drain(10);
        chk("F_hung_busy", busy, 1);
`else
        // no watchdog: hung cam1 keeps sequencer waiting, nothing flagged
        never[1] = 1;
        push(0, 2'b01, 0, -1); push(0, 2'b10, 0, 53);
        pulse_start();
        tick(400);
        drain(10);
        chk("E_hung_busy", busy, 1);
        chk("E_flag", timeout_flag, 0);
        chk("E_mask", timeout_mask, 0);
        chk("E_frame_count", frame_count, 12);
`endif

        // reset in WAIT_DONE aborts with everything cleared
        reset = 1'b1;
        tick();
        check_reset_state();
        reset = 1'b0;
        tick(5);
        chk("end_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imager_capture_sequencer.md
Name: imager_capture_sequencer

Overview:
Parametrised frame-capture scheduler for NUM_CAMS Stonyman camera channels; replaces per-camera software triggering of frame_capture_start. Sits between the APB register interface and the per-camera stonyman controllers. Triggers captures one camera at a time (round-robin) or all at once, paces rounds by a programmable frame period, and watchdogs each capture with a timeout that resets a hung channel.

Parameters:
NUM_CAMS, 2, number of camera channels (1..8)
IDX_W, 3, width of camera index output (ceil log2 NUM_CAMS, min 1)
PERIOD_W, 24, width of frame period counter
TIMEOUT_W, 24, width of per-capture watchdog counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  pulse; begin a round sequence
stop  in  1  pulse; finish current round then go idle
mode  in  2  0=single round, 1=continuous round-robin, 2=simultaneous single, 3=simultaneous continuous
cam_enable  in  NUM_CAMS  channels taking part in a round
frame_period  in  PERIOD_W  minimum cycles between round starts (continuous modes)
timeout_cycles  in  TIMEOUT_W  watchdog limit per capture; 0 disables
clear_status  in  1  pulse; clears timeout_flag and timeout_mask
cam_busy  in  NUM_CAMS  per-camera controller_busy
cam_frame_done  in  NUM_CAMS  per-camera frame_capture_done pulse
cam_frame_start  out  NUM_CAMS  one-cycle frame_capture_start pulses
cam_reset  out  NUM_CAMS  one-cycle per-camera reset on timeout
active_cam  out  IDX_W  index of camera currently captured
busy  out  1  high whenever not IDLE
round_done  out  1  one-cycle pulse at end of each round
timeout_flag  out  1  sticky; any watchdog expiry
timeout_mask  out  NUM_CAMS  sticky; channels that timed out
frame_count  out  16  successful captures, wraps 0xFFFF->0

Behaviour:
- One clock (clk); reset synchronous, active-high. Reset mid-operation aborts to IDLE with no pulses.
- Reset values: all outputs 0; state IDLE; stop_req 0; counters 0.
- States: IDLE, SELECT, WAIT_READY, TRIGGER, WAIT_DONE, PERIOD_WAIT.
- IDLE: start with cam_enable!=0 -> latch mode and cam_enable, clear period counter, ptr=0, -> SELECT. start with cam_enable==0 ignored. start outside IDLE ignored. stop in IDLE ignored.
- Sequential modes (0,1): SELECT picks lowest enabled index >= ptr; sets active_cam -> WAIT_READY. No remaining index -> round end.
- WAIT_READY: wait cam_busy[active]==0 (not watchdogged) -> TRIGGER.
- TRIGGER: cam_frame_start[active]=1 for exactly one cycle, clear watchdog -> WAIT_DONE.
- WAIT_DONE: cam_frame_done[active] -> frame_count+1, ptr=active+1 -> SELECT. Watchdog increments each cycle; reaching timeout_cycles (nonzero) -> cam_reset[active] one cycle, timeout_flag=1, timeout_mask[active]=1, skip to next camera. done and expiry same cycle: done wins, no reset.
- Simultaneous modes (2,3): one TRIGGER cycle pulses all latched enabled bits; WAIT_READY waits until all enabled cam_busy low. WAIT_DONE accumulates done mask, frame_count adds done count per cycle (popcount); leaves when mask==enable. Expiry resets only undone channels.
- Round end: round_done pulse (one cycle, entering PERIOD_WAIT or IDLE). Single modes or stop_req -> IDLE, stop_req cleared. Continuous -> PERIOD_WAIT.
- Period counter counts from round start (saturates). PERIOD_WAIT exits when counter >= frame_period; re-latch cam_enable, clear counter, ptr=0 -> SELECT. Round longer than period -> next round starts the cycle after round_done. Re-latched enable==0 -> IDLE.
- stop pulse anywhere non-IDLE sets stop_req; current round completes.
- cam_frame_done from non-active/non-triggered channels ignored.
- clear_status and new timeout same cycle: set wins.
- busy = (state!=IDLE); active_cam holds last value in IDLE.

Optional Feature:
IMAGER_SEQ_WATCHDOG_EN: defined -> watchdog counter, cam_reset, timeout_flag, timeout_mask behave as above. Undefined -> no watchdog logic; WAIT_DONE waits indefinitely; cam_reset, timeout_flag, timeout_mask tied 0; timeout_cycles and clear_status unused.

Test Plan:
- NUM_CAMS=2, mode=0, enable=2'b11, start; model done 50 cycles after start -> cam_frame_start 01 then 10, one round_done, frame_count=2, busy low after.
- mode=1, frame_period=1000, rounds take ~120 cycles -> round_done spacing exactly 1000 cycles; stop mid-round -> round completes, IDLE, no further starts.
- timeout_cycles=200, cam1 never asserts done -> cam_reset=2'b10 pulse 200 cycles after its trigger, timeout_mask=2'b10, flag=1, round_done follows; clear_status clears both.
- mode=2, enable=2'b11, cam_busy[1] high 30 cycles -> single trigger 2'b11 after busy drops; dones at different cycles -> frame_count=2, one round_done.
- done and watchdog expiry same cycle -> no cam_reset, frame_count increments; reset asserted in WAIT_DONE -> all outputs 0 next cycle.
- enable=2'b10 with start -> only cam1 triggered, active_cam=1; start with enable=0 -> busy stays 0.
